// File: rtl/debug_sequencer.sv
// rtl/debug_sequencer.sv - run/step/halt controller and state-dump serialiser for the pipeline debug port
module debug_sequencer #(
    parameter int         RAM_WORDS = 32,
    parameter logic [7:0] CMD_RUN   = 8'h63,
    parameter logic [7:0] CMD_STEP  = 8'h73,
    parameter logic [7:0] CMD_DUMP  = 8'h64,
    parameter logic [7:0] CMD_PAUSE = 8'h70
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    input  logic        fin,
    input  logic [31:0] pc_value,
    output logic        pipe_enable,
    output logic [4:0]  dir_fr,
    input  logic [31:0] dato_fr,
    output logic [31:0] dir_ram,
    input  logic [31:0] dato_ram,
    output logic        busy,
    output logic        halted
);

    localparam int N  = 34 + RAM_WORDS;
    localparam int WW = $clog2(N + 1);

    localparam logic [WW-1:0] W_PC     = WW'(1);
    localparam logic [WW-1:0] W_REG0   = WW'(2);
    localparam logic [WW-1:0] W_RAM0   = WW'(34);
    localparam logic [WW-1:0] W_LAST   = WW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_SNAP,
        S_FETCH,
        S_LATCH,
        S_SEND,
        S_WAIT_TX
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [31:0]    cycle_cnt;
    logic [31:0]    snap_cnt;
    logic [31:0]    snap_pc;
    logic [31:0]    shift;
    logic [31:0]    sel_word;
    logic [WW-1:0]  w;
    logic [WW-1:0]  w_m2;
    logic [WW-1:0]  w_m34;
    logic [1:0]     b;
    logic           is_reg;
    logic           is_ram;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A halted core never re-enables the pipeline; run/step degrade to a plain dump.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (rx_done) begin
                    if (rx_data == CMD_RUN) begin
                        state_next = halted ? S_SNAP : S_RUN;
                    end else if (rx_data == CMD_STEP) begin
                        state_next = halted ? S_SNAP : S_STEP;
                    end else if (rx_data == CMD_DUMP) begin
                        state_next = S_SNAP;
                    end
                end
            end
            S_RUN: begin
                if (fin || (rx_done && (rx_data == CMD_PAUSE))) begin
                    state_next = S_SNAP;
                end
            end
            S_STEP:  state_next = S_SNAP;
            S_SNAP:  state_next = S_FETCH;
            S_FETCH: state_next = S_LATCH;
            S_LATCH: state_next = S_SEND;
            S_SEND:  state_next = S_WAIT_TX;
            S_WAIT_TX: begin
                if (tx_done) begin
                    if (b != 2'd3) begin
                        state_next = S_SEND;
                    end else if (w != W_LAST) begin
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pipe_enable = 1'b0;
        tx_start    = 1'b0;
        busy        = 1'b1;
        case (state)
            S_IDLE:  busy        = 1'b0;
            S_RUN:   pipe_enable = 1'b1;
            S_STEP:  pipe_enable = 1'b1;
            S_SEND:  tx_start    = 1'b1;
            default: ;
        endcase
    end

    // Debug read addresses follow the word index so they stay put across FETCH/LATCH.
    always_comb begin
        w_m2    = w - W_REG0;
        w_m34   = w - W_RAM0;
        is_reg  = (w >= W_REG0) && (w < W_RAM0);
        is_ram  = (w >= W_RAM0);
        dir_fr  = is_reg ? w_m2[4:0] : 5'd0;
        dir_ram = is_ram ? 32'(w_m34) : 32'd0;
    end

    always_comb begin
        sel_word = dato_ram;
        if (w == '0) begin
            sel_word = snap_cnt;
        end else if (w == W_PC) begin
            sel_word = snap_pc;
        end else if (is_reg) begin
            sel_word = dato_fr;
        end
    end

    assign tx_data = shift[31:24];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted    <= 1'b0;
            cycle_cnt <= 32'd0;
            snap_cnt  <= 32'd0;
            snap_pc   <= 32'd0;
            shift     <= 32'd0;
            w         <= '0;
            b         <= 2'd0;
        end else begin
            if (pipe_enable && (cycle_cnt != 32'hFFFF_FFFF)) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (((state == S_RUN) || (state == S_STEP)) && fin) begin
                halted <= 1'b1;
            end
            case (state)
                S_SNAP: begin
                    snap_cnt <= cycle_cnt;
                    snap_pc  <= pc_value;
                    w        <= '0;
                end
                S_LATCH: begin
                    shift <= sel_word;
                    b     <= 2'd0;
                end
                S_WAIT_TX: begin
                    if (tx_done) begin
                        shift <= {shift[23:0], 8'h00};
                        b     <= b + 2'd1;
                        if ((b == 2'd3) && (w != W_LAST)) begin
                            w <= w + WW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/debug_sequencer.md
Name: debug_sequencer

Overview:
- Run/step/halt controller for the 5-stage pipeline, plus a state-dump sequencer. Sits between the UART byte interface and the pipeline.
- Decodes host command bytes and drives the global pipeline enable.
- Counts executed cycles.
- Walks the register-file and data-RAM debug read ports, serialising a snapshot to the UART transmitter byte by byte.

Parameters:
- RAM_WORDS, 32, number of data-RAM words included in each dump (1..1024).
- CMD_RUN, 8'h63, command byte 'c': run until fin or pause.
- CMD_STEP, 8'h73, command byte 's': single step, then dump.
- CMD_DUMP, 8'h64, command byte 'd': dump only.
- CMD_PAUSE, 8'h70, command byte 'p': stop a run, then dump.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- rx_data  in  8  received UART byte.
- rx_done  in  1  one-cycle pulse: rx_data valid.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- tx_done  in  1  one-cycle pulse: transmitter finished the current byte.
- fin  in  1  program-end flag from the MEM/WB stage.
- pc_value  in  32  current PC register value.
- pipe_enable  out  1  global enable for PC, IF/ID and control (1 = advance).
- dir_fr  out  5  register-file debug read address.
- dato_fr  in  32  register-file debug read data, valid 1 cycle after dir_fr.
- dir_ram  out  32  data-RAM debug word address.
- dato_ram  in  32  data-RAM debug read data, valid 1 cycle after dir_ram.
- busy  out  1  high outside IDLE.
- halted  out  1  sticky: fin has been seen since reset.

Behaviour:
- Reset (async) values: state IDLE; pipe_enable, tx_start, busy, halted = 0; tx_data = 0; dir_fr = 0; dir_ram = 0; cycle_cnt = 0. Reset mid-operation aborts immediately; no partial byte is re-sent.
- States: IDLE, RUN, STEP, SNAP, FETCH, LATCH, SEND, WAIT_TX.
- IDLE, on rx_done:
  - CMD_RUN goes to RUN; CMD_STEP goes to STEP; CMD_DUMP goes to SNAP.
  - If halted = 1, CMD_RUN and CMD_STEP go directly to SNAP and pipe_enable stays 0.
  - All other bytes are ignored.
- RUN: pipe_enable = 1 while in RUN.
  - fin = 1 sampled: set halted, go to SNAP; pipe_enable is 0 from the next cycle.
  - rx_done with CMD_PAUSE: go to SNAP. If fin is sampled in the same cycle, fin takes priority (halted is set).
  - Any other rx_done is ignored.
- STEP: pipe_enable = 1 for exactly one cycle, then SNAP. If fin is high in that cycle, set halted.
- cycle_cnt: increments on every cycle with pipe_enable = 1; saturates at 32'hFFFF_FFFF.
- SNAP (1 cycle): capture cycle_cnt and pc_value into snapshot registers; set word index w = 0.
- Dump frame: N = 34 + RAM_WORDS words, each sent MSB first, 4*N bytes total.
  - w = 0: cycle_cnt snapshot.
  - w = 1: PC snapshot.
  - w = 2..33: register (w-2), via dir_fr = w-2.
  - w = 34..N-1: RAM word (w-34), via dir_ram = w-34.
- FETCH: drive the address, hold it stable. LATCH: wait the one-cycle read latency, then load the selected data into a 32-bit shift register; set byte count b = 0.
- SEND: tx_data = shift[31:24]; tx_start pulses for exactly 1 cycle; go to WAIT_TX.
- WAIT_TX: tx_data held stable until tx_done. On tx_done, shift left 8 and b++:
  - b < 3: go to SEND.
  - else if w < N-1: w++, go to FETCH.
  - else: go to IDLE.
- tx_done outside WAIT_TX is ignored. rx_done outside IDLE/RUN is ignored; commands are not queued.
- busy = 1 in every state except IDLE.
- Minimum bytes between tx_start pulses: 2 cycles when tx_done returns immediately; a new word adds 2 cycles (FETCH, LATCH).

Test Plan:
1. Reset; send 's' with RAM_WORDS=32 → pipe_enable high exactly 1 cycle; exactly 264 tx_start pulses; bytes 0-3 = 00 00 00 01; bytes 4-7 = pc_value at SNAP.
2. Preload reg5 = 32'hDEADBEEF and RAM word 3 = 32'h01020304; send 'd' → bytes 28-31 = DE AD BE EF; bytes 148-151 = 01 02 03 04; pipe_enable stays 0.
3. Send 'c'; assert fin on the 100th enabled cycle → pipe_enable 0 the following cycle; halted = 1; dump bytes 0-3 = 00 00 00 64. A subsequent 's' produces no pipe_enable pulse and the same count 00 00 00 64.
4. In RUN, assert rx_done with 'p' and fin in the same cycle → halted = 1, SNAP entered next cycle; a byte 'x' in IDLE → no state change, busy stays 0.
5. Delay tx_done by 50 cycles per byte → tx_data constant throughout each wait; no second tx_start before tx_done; extra tx_done pulses in FETCH are ignored.
6. Assert reset after the 10th tx_start of a dump → all outputs at reset values within the same cycle; next 'd' restarts at byte 0 with cycle count 00 00 00 00.
